// File: rtl/cache_port_arbiter.sv
// Shares one cache port between instruction fetch (IF) and load/store (LS).
// Define CACHE_ARB_RR_EN for round-robin arbitration; fixed LS-over-IF otherwise.
module cache_port_arbiter #(
  parameter int CACHE_LAT = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_op,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              c_en,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_i_val,
  output logic              c_op_type,
  input  logic [DATA_W-1:0] c_o_val
);

  localparam int CNT_W = $clog2(CACHE_LAT) + 1;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_IF, OWN_LS} own_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              op;
  } req_t;

  state_t           state;
  own_t             owner;
  logic [CNT_W-1:0] cnt;
  own_t             win;
  req_t             win_req;

`ifdef CACHE_ARB_RR_EN
  own_t last_gnt;

  // On contention the side not granted last time wins.
  always_comb begin
    win = OWN_IF;
    if (ls_req && (!if_req || last_gnt == OWN_IF))
      win = OWN_LS;
  end
`else
  always_comb begin
    win = ls_req ? OWN_LS : OWN_IF;
  end
`endif

  // IF accesses are always reads with no write data.
  always_comb begin
    win_req.addr  = if_addr;
    win_req.wdata = '0;
    win_req.op    = 1'b0;
    if (win == OWN_LS) begin
      win_req.addr  = ls_addr;
      win_req.wdata = ls_wdata;
      win_req.op    = ls_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_LS;
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      ls_gnt    <= 1'b0;
      ls_valid  <= 1'b0;
      ls_rdata  <= '0;
      c_en      <= 1'b0;
      c_address <= '0;
      c_i_val   <= '0;
      c_op_type <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_gnt  <= OWN_LS;
`endif
    end else begin
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            c_address <= win_req.addr;
            c_i_val   <= win_req.wdata;
            c_op_type <= win_req.op;
            c_en      <= 1'b1;
            cnt       <= CNT_W'(CACHE_LAT - 1);
            owner     <= win;
            if_gnt    <= (win == OWN_IF);
            ls_gnt    <= (win == OWN_LS);
`ifdef CACHE_ARB_RR_EN
            last_gnt  <= win;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // c_address/c_i_val/c_op_type intentionally keep their last values.
            c_en  <= 1'b0;
            state <= IDLE;
            if (owner == OWN_IF) begin
              if_rdata <= c_o_val;
              if_valid <= 1'b1;
            end else begin
              if (!c_op_type)
                ls_rdata <= c_o_val;
              ls_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter (CACHE_LAT=2): reset, IF read, LS write,
// contested arbitration order and reset in the middle of an access.
module tb_cache_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_op;
  logic [31:0] if_addr, ls_addr, ls_wdata, c_o_val;
  logic        if_gnt, if_valid, ls_gnt, ls_valid, c_en, c_op_type;
  logic [31:0] if_rdata, ls_rdata, c_address, c_i_val;

  int n_chk  = 0;
  int n_pass = 0;

  cache_port_arbiter #(.CACHE_LAT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .c_en(c_en), .c_address(c_address), .c_i_val(c_i_val), .c_op_type(c_op_type),
    .c_o_val(c_o_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   ng;
  logic gown [4];
  int   gcyc [4];
  logic both_valid;

  initial begin
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_op = 1'b0;
    if_addr = 32'h1; ls_addr = 32'h2; ls_wdata = 32'h3; c_o_val = 32'h5;

    // reset with both requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_c_en",   c_en,   0);
    end
    chk("rst_valid", {if_valid, ls_valid}, 0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 0);
    chk("rst_c_bus", {c_address, c_i_val, c_op_type}, 0);
    if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
    tick();
    chk("idle_c_en", c_en, 0);

    // IF read of 0x10
    if_req = 1'b1; if_addr = 32'h10; c_o_val = 32'hDEADBEEF;
    tick();
    chk("ifr_gnt",   {if_gnt, ls_gnt}, 2'b10);
    chk("ifr_c_en",  c_en, 1);
    chk("ifr_addr",  c_address, 32'h10);
    chk("ifr_op",    c_op_type, 0);
    if_req = 1'b0;
    tick();
    chk("ifr_gnt_low", if_gnt, 0);
    chk("ifr_c_en2",   c_en, 1);
    chk("ifr_no_val",  if_valid, 0);
    tick();
    chk("ifr_valid", {if_valid, ls_valid}, 2'b10);
    chk("ifr_rdata", if_rdata, 32'hDEADBEEF);
    chk("ifr_c_off", c_en, 0);
    chk("ifr_addr_hold", c_address, 32'h10);
    tick();
    chk("ifr_pulse", if_valid, 0);
    chk("ifr_rdata_hold", if_rdata, 32'hDEADBEEF);

    // LS write of 0x1234 to 0x20
    ls_req = 1'b1; ls_op = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h1234; c_o_val = 32'hCAFEF00D;
    tick();
    chk("lsw_gnt",  {if_gnt, ls_gnt}, 2'b01);
    chk("lsw_bus",  {c_en, c_op_type, c_address, c_i_val}, {2'b11, 32'h20, 32'h1234});
    ls_req = 1'b0;
    tick();
    chk("lsw_bus2", {c_en, c_op_type, c_address, c_i_val}, {2'b11, 32'h20, 32'h1234});
    chk("lsw_no_val", ls_valid, 0);
    tick();
    chk("lsw_valid", {if_valid, ls_valid}, 2'b01);
    chk("lsw_rdata", ls_rdata, 0);
    chk("lsw_c_off", c_en, 0);
    tick();
    chk("lsw_pulse", ls_valid, 0);

    // contested: both requests held for four grants
    if_req = 1'b1; ls_req = 1'b1; ls_op = 1'b0;
    if_addr = 32'h50; ls_addr = 32'h30; c_o_val = 32'h0BADCAFE;
    ng = 0; both_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if_valid && ls_valid) both_valid = 1'b1;
      if ((if_gnt || ls_gnt) && ng < 4) begin
        gown[ng] = ls_gnt;
        gcyc[ng] = c;
        ng++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    tick();
    chk("arb_count", ng, 4);
    chk("arb_both_valid", both_valid, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef CACHE_ARB_RR_EN
      chk($sformatf("arb_owner%0d", i), gown[i], (i % 2 == 1));
`else
      chk($sformatf("arb_owner%0d", i), gown[i], 1);
`endif
      chk($sformatf("arb_cycle%0d", i), gcyc[i], 3 * i);
    end
    chk("arb_ls_rdata", ls_rdata, 32'h0BADCAFE);
`ifdef CACHE_ARB_RR_EN
    chk("arb_if_rdata", if_rdata, 32'h0BADCAFE);
`else
    chk("arb_if_rdata", if_rdata, 32'hDEADBEEF);
`endif

    // reset in the second ACCESS cycle of an LS read
    ls_req = 1'b1; ls_op = 1'b0; ls_addr = 32'h60; c_o_val = 32'h66666666;
    tick();
    chk("mid_gnt", ls_gnt, 1);
    ls_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_valid", {if_valid, ls_valid}, 0);
    chk("mid_outs", {c_en, c_address, ls_rdata, if_rdata}, 0);
    rst = 1'b1;
    tick();
    chk("mid_no_late_valid", ls_valid, 0);

    if_req = 1'b1; if_addr = 32'h40; c_o_val = 32'h40404040;
    tick();
    chk("post_gnt",  {if_gnt, c_en, c_address}, {2'b11, 32'h40});
    if_req = 1'b0;
    tick();
    tick();
    chk("post_valid", {if_valid, ls_valid}, 2'b10);
    chk("post_rdata", if_rdata, 32'h40404040);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
